// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the register access arbiter.
// Index/counter widths come from the instantiating parameters via the helpers below.
package reg_arb_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      WAIT_RD = 1'b1
   } arb_state_e;

   // Upper bounds for the generic field slicer; wide enough for 8 requesters of 512-bit data.
   localparam int MAX_BUS   = 4096;
   localparam int MAX_FIELD = 512;

   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int cnt_width(input int t);
      return (t < 2) ? 1 : $clog2(t);
   endfunction

   function automatic logic [MAX_FIELD-1:0] slice_field(input logic [MAX_BUS-1:0] bus,
                                                        input int idx, input int width);
      return MAX_FIELD'(bus >> (idx * width));
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after (i_last_idx + 1) mod N.
// Outputs a one-hot grant and the matching binary index.
module rr_arbiter
   import reg_arb_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0]              i_req,
   input  logic [idx_width(N)-1:0]   i_last_idx,
   output logic [N-1:0]              o_grant,
   output logic [idx_width(N)-1:0]   o_idx
);

   localparam int IW = idx_width(N);

   int   pos;
   logic found;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      found   = 1'b0;
      pos     = 0;
      for (int off = 1; off <= N; off++) begin
         pos = (int'(i_last_idx) + off) % N;
         if (!found && i_req[pos]) begin
            found        = 1'b1;
            o_grant[pos] = 1'b1;
            o_idx        = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/reg_access_arbiter.sv
// Shares one register-block port among NUM_REQ requesters with round-robin grant,
// one strobe per accepted request, and read responses routed back to the issuer.
module reg_access_arbiter
   import reg_arb_pkg::*;
#(
   parameter int WORD_WIDTH = 8,
   parameter int REG_WIDTH  = 4,
   parameter int NUM_REQ    = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic                                  clk,
   input  logic                                  i_reset,
   input  logic [NUM_REQ-1:0]                    i_req_valid,
   input  logic [NUM_REQ-1:0]                    i_req_we,
   input  logic [NUM_REQ*WORD_WIDTH-1:0]         i_req_addr,
   input  logic [NUM_REQ*REG_WIDTH*WORD_WIDTH-1:0] i_req_value,
   output logic [NUM_REQ-1:0]                    o_req_ready,
   output logic [NUM_REQ-1:0]                    o_rsp_valid,
   output logic [REG_WIDTH*WORD_WIDTH-1:0]       o_rsp_data,
   output logic                                  o_rsp_err,
   output logic                                  o_w_en,
   output logic                                  o_r_en,
   output logic [WORD_WIDTH-1:0]                 o_addr,
   output logic [REG_WIDTH*WORD_WIDTH-1:0]       o_value,
   input  logic [REG_WIDTH*WORD_WIDTH-1:0]       i_r_value,
   input  logic                                  i_r_valid,
   output logic                                  o_busy
);

   localparam int DW = REG_WIDTH * WORD_WIDTH;
   localparam int IW = idx_width(NUM_REQ);
   localparam int CW = cnt_width(TIMEOUT);

   arb_state_e         state;
   logic [IW-1:0]      last_grant;
   logic [IW-1:0]      owner;
   logic [IW-1:0]      win_idx;
   logic [CW-1:0]      cnt;
   logic [NUM_REQ-1:0] grant;
   logic               accept;
   logic               win_we;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .i_req      (i_req_valid),
      .i_last_idx (last_grant),
      .o_grant    (grant),
      .o_idx      (win_idx)
   );

   // Handshake: a request transfers in any cycle where its valid and ready are both high.
   // Ready is only offered in IDLE, and never while reset is asserted.
   assign o_req_ready = (state == IDLE && !i_reset) ? grant : '0;
   assign accept      = |o_req_ready;
   assign win_we      = |(o_req_ready & i_req_we);
   assign o_busy      = (state == WAIT_RD);

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         state       <= IDLE;
         last_grant  <= IW'(NUM_REQ - 1);
         owner       <= '0;
         cnt         <= '0;
         o_rsp_valid <= '0;
         o_rsp_data  <= '0;
         o_rsp_err   <= 1'b0;
         o_w_en      <= 1'b0;
         o_r_en      <= 1'b0;
         o_addr      <= '0;
         o_value     <= '0;
      end else begin
         o_w_en      <= 1'b0;
         o_r_en      <= 1'b0;
         o_rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  last_grant <= win_idx;
                  o_addr     <= WORD_WIDTH'(slice_field(MAX_BUS'(i_req_addr), int'(win_idx), WORD_WIDTH));
                  if (win_we) begin
                     o_w_en  <= 1'b1;
                     o_value <= DW'(slice_field(MAX_BUS'(i_req_value), int'(win_idx), DW));
                  end else begin
                     o_r_en <= 1'b1;
                     owner  <= win_idx;
                     cnt    <= '0;
                     state  <= WAIT_RD;
                  end
               end
            end
            WAIT_RD: begin
               // A valid response in the same cycle as the timeout takes precedence.
               if (i_r_valid) begin
                  o_rsp_data  <= i_r_value;
                  o_rsp_err   <= 1'b0;
                  o_rsp_valid <= NUM_REQ'(1) << owner;
                  state       <= IDLE;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  o_rsp_data  <= '0;
                  o_rsp_err   <= 1'b1;
                  o_rsp_valid <= NUM_REQ'(1) << owner;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Bench for reg_access_arbiter: directed scenarios then random traffic, all checked
// cycle by cycle against a transaction-level model of grant order, strobes and responses.
module tb_reg_access_arbiter;

   localparam int NREQ = 2;
   localparam int TO   = 8;

   logic        clk;
   logic        i_reset;
   logic [1:0]  i_req_valid;
   logic [1:0]  i_req_we;
   logic [15:0] i_req_addr;
   logic [63:0] i_req_value;
   logic [1:0]  o_req_ready;
   logic [1:0]  o_rsp_valid;
   logic [31:0] o_rsp_data;
   logic        o_rsp_err;
   logic        o_w_en;
   logic        o_r_en;
   logic [7:0]  o_addr;
   logic [31:0] o_value;
   logic [31:0] i_r_value;
   logic        i_r_valid;
   logic        o_busy;

   reg_access_arbiter #(.WORD_WIDTH(8), .REG_WIDTH(4), .NUM_REQ(NREQ), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .i_reset     (i_reset),
      .i_req_valid (i_req_valid),
      .i_req_we    (i_req_we),
      .i_req_addr  (i_req_addr),
      .i_req_value (i_req_value),
      .o_req_ready (o_req_ready),
      .o_rsp_valid (o_rsp_valid),
      .o_rsp_data  (o_rsp_data),
      .o_rsp_err   (o_rsp_err),
      .o_w_en      (o_w_en),
      .o_r_en      (o_r_en),
      .o_addr      (o_addr),
      .o_value     (o_value),
      .i_r_value   (i_r_value),
      .i_r_valid   (i_r_valid),
      .o_busy      (o_busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // requester drivers
   logic [1:0]  d_valid, d_we;
   logic [7:0]  d_addr [2];
   logic [31:0] d_value [2];
   logic        d_stray;

   // register-block emulation
   bit          rb_active;
   int          rb_lat, rb_since, rb_next_lat;
   logic [31:0] rb_data;

   // model state and expected registered outputs
   int          m_last, m_owner, m_since, m_win;
   bit          m_pend;
   logic        e_w_en, e_r_en, e_busy, e_rsp_err;
   logic [1:0]  e_rsp_valid;
   logic [31:0] e_rsp_data, e_value;
   logic [7:0]  e_addr;
   logic [1:0]  last_ready;

   // scoreboard of expected strobes: {we, addr, value-if-write}
   logic [40:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int winner(input logic [1:0] v, input int last);
      for (int off = 1; off <= NREQ; off++) begin
         int k = (last + off) % NREQ;
         if (v[k]) return k;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_last = NREQ - 1; m_pend = 0; m_owner = 0; m_since = 0; m_win = -1;
      rb_active = 0; rb_since = 0; rb_lat = 0;
      e_w_en = 0; e_r_en = 0; e_busy = 0; e_rsp_err = 0; e_rsp_valid = '0;
      e_rsp_data = '0; e_value = '0; e_addr = '0;
      exp_q.delete();
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_ready"}, o_req_ready, 0);
      check({pfx, "_rsp_valid"}, o_rsp_valid, 0);
      check({pfx, "_rsp_err"}, o_rsp_err, 0);
      check({pfx, "_rsp_data"}, o_rsp_data, 0);
      check({pfx, "_w_en"}, o_w_en, 0);
      check({pfx, "_r_en"}, o_r_en, 0);
      check({pfx, "_addr"}, o_addr, 0);
      check({pfx, "_value"}, o_value, 0);
      check({pfx, "_busy"}, o_busy, 0);
   endtask

   // One clock cycle: check registered outputs, drive inputs, check ready, predict next state.
   task automatic cycle();
      logic [1:0]  rdy;
      logic [40:0] ent;
      logic        rv;
      @(negedge clk);
      cyc++;
      check("w_en", o_w_en, e_w_en);
      check("r_en", o_r_en, e_r_en);
      check("addr", o_addr, e_addr);
      check("value", o_value, e_value);
      check("rsp_valid", o_rsp_valid, e_rsp_valid);
      check("rsp_err", o_rsp_err, e_rsp_err);
      check("rsp_data", o_rsp_data, e_rsp_data);
      check("busy", o_busy, e_busy);
      if (o_w_en || o_r_en) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL strobe_q: observed strobe addr %0h, expected no strobe", o_addr);
         end
         if (exp_q.size() != 0) begin
            ent = exp_q.pop_front();
            check("strobe", {o_w_en, o_addr, o_w_en ? o_value : 32'h0}, ent);
         end
      end
      if (e_r_en) begin
         rb_active = 1; rb_since = 0; rb_lat = rb_next_lat;
      end
      rv = rb_active && (rb_since == rb_lat);
      if (rv) rb_active = 0;
      i_r_valid   = rv || d_stray;
      i_r_value   = rb_data;
      i_req_valid = d_valid;
      i_req_we    = d_we;
      i_req_addr  = {d_addr[1], d_addr[0]};
      i_req_value = {d_value[1], d_value[0]};
      #1;
      m_win = m_pend ? -1 : winner(d_valid, m_last);
      rdy   = (m_win < 0) ? 2'b00 : (2'b01 << m_win);
      check("ready", o_req_ready, rdy);
      last_ready = o_req_ready;
      e_w_en = 0; e_r_en = 0; e_rsp_valid = '0;
      if (m_pend) begin
         if (i_r_valid) begin
            e_rsp_valid = 2'b01 << m_owner; e_rsp_err = 0; e_rsp_data = i_r_value; m_pend = 0;
         end else if (m_since == TO - 1) begin
            e_rsp_valid = 2'b01 << m_owner; e_rsp_err = 1; e_rsp_data = '0; m_pend = 0;
         end
         m_since++;
      end else if (m_win >= 0) begin
         m_last = m_win;
         e_addr = d_addr[m_win];
         if (d_we[m_win]) begin
            e_w_en  = 1;
            e_value = d_value[m_win];
            exp_q.push_back({1'b1, d_addr[m_win], d_value[m_win]});
         end else begin
            e_r_en  = 1;
            m_pend  = 1;
            m_owner = m_win;
            m_since = 0;
            exp_q.push_back({1'b0, d_addr[m_win], 32'h0});
         end
      end
      e_busy = m_pend;
      if (rb_active) rb_since++;
   endtask

   task automatic reset_mid();
      i_req_valid = 2'b11;
      i_reset     = 1'b1;
      #2;
      check_all_zero("rst_mid");
      i_req_valid = '0; d_valid = '0; d_stray = 0; i_r_valid = 0;
      model_reset();
      @(negedge clk);
      i_reset = 1'b0;
   endtask

   initial begin
      int grants [6];
      int wcnt, t0, t1;
      bit got;

      i_reset = 1'b1;
      i_req_valid = '0; i_req_we = '0; i_req_addr = '0; i_req_value = '0;
      i_r_valid = 0; i_r_value = '0;
      d_valid = '0; d_we = '0; d_stray = 0;
      d_addr[0] = '0; d_addr[1] = '0; d_value[0] = '0; d_value[1] = '0;
      rb_next_lat = 99; rb_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_all_zero("reset");
      i_reset = 1'b0;

      // single write from requester 0
      d_valid = 2'b01; d_we = 2'b01; d_addr[0] = 8'h05; d_value[0] = 32'hDEADBEEF;
      cycle();
      check("wr_ready", last_ready, 2'b01);
      d_valid = '0;
      cycle();
      check("wr_w_en", o_w_en, 1);
      check("wr_addr", o_addr, 8'h05);
      check("wr_value", o_value, 32'hDEADBEEF);
      check("wr_no_rsp", o_rsp_valid, 0);

      // read from requester 1, register block answers three cycles after the strobe
      d_valid = 2'b10; d_we = 2'b00; d_addr[1] = 8'h0A; rb_next_lat = 3; rb_data = 32'h12345678;
      cycle();
      check("rd_ready", last_ready, 2'b10);
      d_valid = '0;
      cycle();
      check("rd_r_en", o_r_en, 1);
      check("rd_addr", o_addr, 8'h0A);
      check("rd_value_hold", o_value, 32'hDEADBEEF);
      check("rd_busy0", o_busy, 1);
      for (int n = 0; n < 3; n++) begin
         cycle();
         check("rd_busy", o_busy, 1);
      end
      cycle();
      check("rd_rsp_valid", o_rsp_valid, 2'b10);
      check("rd_rsp_err", o_rsp_err, 0);
      check("rd_rsp_data", o_rsp_data, 32'h12345678);
      check("rd_busy_end", o_busy, 0);

      // fairness: both requesters stream writes
      d_valid = 2'b11; d_we = 2'b11;
      d_addr[0] = 8'($urandom); d_addr[1] = 8'($urandom);
      d_value[0] = $urandom; d_value[1] = $urandom;
      wcnt = 0;
      for (int n = 0; n < 6; n++) begin
         cycle();
         grants[n] = last_ready[1] ? 1 : (last_ready[0] ? 0 : -1);
         if (n > 0) wcnt += int'(o_w_en);
         if (grants[n] >= 0) begin
            d_addr[grants[n]]  = 8'($urandom);
            d_value[grants[n]] = $urandom;
         end
      end
      d_valid = '0;
      cycle();
      wcnt += int'(o_w_en);
      for (int n = 0; n < 6; n++) check("fair_grant", grants[n], n % 2);
      check("fair_w_en_run", wcnt, 6);

      // timeout: register block answers only after the timeout has fired
      d_valid = 2'b01; d_we = 2'b00; d_addr[0] = 8'h33; rb_next_lat = 10; rb_data = 32'hA5A5A5A5;
      cycle();
      d_valid = '0;
      t0 = -1; t1 = -1;
      for (int n = 0; n < 20 && t1 < 0; n++) begin
         cycle();
         if (o_r_en) t0 = cyc;
         if (o_rsp_valid != 0) t1 = cyc;
      end
      check("to_latency", t1 - t0, TO);
      check("to_rsp_valid", o_rsp_valid, 2'b01);
      check("to_rsp_err", o_rsp_err, 1);
      check("to_rsp_data", o_rsp_data, 0);
      for (int n = 0; n < 4; n++) begin
         cycle();
         check("to_late_ignored", o_rsp_valid, 0);
      end

      // read blocking: requester 1 write waits behind requester 0 read
      d_valid = 2'b01; d_we = 2'b00; d_addr[0] = 8'h44; rb_next_lat = 2; rb_data = 32'h0BADF00D;
      cycle();
      check("blk_rd_ready", last_ready, 2'b01);
      d_valid = 2'b10; d_we = 2'b10; d_addr[1] = 8'h55; d_value[1] = 32'hCAFEF00D;
      got = 0;
      for (int n = 0; n < 12 && !got; n++) begin
         cycle();
         if (o_rsp_valid[0]) begin
            got = 1;
            check("blk_ready_rsp", last_ready, 2'b10);
         end else begin
            check("blk_ready_hold", last_ready[1], 0);
         end
      end
      check("blk_rsp_seen", got, 1);
      d_valid = '0;
      cycle();
      check("blk_w_en", o_w_en, 1);
      check("blk_addr", o_addr, 8'h55);
      check("blk_value", o_value, 32'hCAFEF00D);

      // reset while a read is outstanding
      d_valid = 2'b10; d_we = 2'b00; d_addr[1] = 8'h66; rb_next_lat = 99;
      cycle();
      d_valid = '0;
      cycle();
      cycle();
      check("rst_busy_before", o_busy, 1);
      reset_mid();
      d_valid = 2'b11; d_we = 2'b11; d_addr[0] = 8'h70; d_addr[1] = 8'h71;
      d_value[0] = 32'h7000_0000; d_value[1] = 32'h7100_0000;
      cycle();
      check("rst_next_prio0", last_ready, 2'b01);
      d_valid = 2'b10;
      cycle();
      check("rst_next_req1", last_ready, 2'b10);
      d_valid = '0;
      cycle();
      check("rst_w_en_req1", o_w_en, 1);
      check("rst_addr_req1", o_addr, 8'h71);

      // random traffic: mixed reads/writes, withdrawn requests, stray and late read data
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!d_valid[k]) begin
               if ($urandom_range(0, 2) == 0) begin
                  d_valid[k] = 1'b1;
                  d_we[k]    = 1'($urandom_range(0, 1));
                  d_addr[k]  = 8'($urandom);
                  d_value[k] = $urandom;
               end
            end else if ($urandom_range(0, 15) == 0) begin
               d_valid[k] = 1'b0;
            end
         end
         d_stray     = ($urandom_range(0, 15) == 0);
         rb_next_lat = $urandom_range(0, 10);
         rb_data     = $urandom;
         cycle();
         if (m_win >= 0) d_valid[m_win] = 1'b0;
      end
      d_valid = '0; d_stray = 0;
      repeat (16) cycle();
      check("drain_q", exp_q.size(), 0);
      check("drain_busy", o_busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
Shares one register-block access port (write strobe/addr/value, read strobe/addr, read value/valid) between NUM_REQ requesters, e.g. the UART command path plus a local sequencer. Uses a round-robin grant with a valid/ready request handshake. Issues exactly one register-block strobe per accepted request. Routes each read response back to the requester that issued it, with a timeout if the register block never returns i_r_valid.

Parameters:
WORD_WIDTH, 8, bits per word; also the address width.
REG_WIDTH, 4, register width in words; data width is REG_WIDTH*WORD_WIDTH.
NUM_REQ, 2, number of requesters (2..8).
TIMEOUT, 255, cycles to wait for i_r_valid after o_r_en before an error response (>=2).

Ports:
clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_req_valid  in  NUM_REQ  per-requester request valid
i_req_we  in  NUM_REQ  1 = write, 0 = read
i_req_addr  in  NUM_REQ*WORD_WIDTH  packed addresses, requester k at slice k
i_req_value  in  NUM_REQ*REG_WIDTH*WORD_WIDTH  packed write data
o_req_ready  out  NUM_REQ  one-hot accept for the granted requester
o_rsp_valid  out  NUM_REQ  one-cycle read-response pulse to the issuing requester
o_rsp_data  out  REG_WIDTH*WORD_WIDTH  read data, shared by all requesters
o_rsp_err  out  1  qualifies o_rsp_valid: 1 = timeout
o_w_en  out  1  register write strobe
o_r_en  out  1  register read strobe
o_addr  out  WORD_WIDTH  register address, shared by read and write
o_value  out  REG_WIDTH*WORD_WIDTH  register write value
i_r_value  in  REG_WIDTH*WORD_WIDTH  register read data
i_r_valid  in  1  register read data valid
o_busy  out  1  high while in WAIT_RD

Behaviour:
- Reset (asynchronous): all outputs 0, state IDLE, round-robin pointer set so requester 0 has highest priority, timeout counter 0.
- FSM states: IDLE and WAIT_RD.
- IDLE grant:
  - o_req_ready is combinational: one-hot grant to the first valid requester at or after (last_grant+1) mod NUM_REQ. All zero in WAIT_RD or when no request is valid.
  - A request transfers when valid and ready are both high at cycle T. Requesters hold valid and payload stable until ready.
  - On accept, last_grant is updated to the winner.
- Write accepted at T:
  - o_w_en=1 at T+1 for exactly one cycle, with o_addr/o_value registered from the winner.
  - State stays IDLE, so back-to-back writes sustain 1 per cycle.
- Read accepted at T:
  - o_r_en=1 at T+1 for one cycle with o_addr; o_value holds its previous value.
  - State is WAIT_RD from T+1; the issuing requester index is latched; the counter clears.
- WAIT_RD:
  - i_r_valid is sampled from T+1 onward, so a zero-latency register block works.
  - On i_r_valid: o_rsp_data <= i_r_value, o_rsp_valid[owner]=1 and o_rsp_err=0 next cycle; return to IDLE.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without i_r_valid: o_rsp_valid[owner]=1, o_rsp_err=1, o_rsp_data=0 next cycle; return to IDLE.
  - If i_r_valid and the timeout fall in the same cycle, the valid response wins.
- The first new grant is possible in the same cycle the response pulse is driven.
- i_r_valid arriving in IDLE (stray or late after a timeout) is ignored; no response is generated.
- o_rsp_valid, o_w_en and o_r_en are one-cycle pulses. o_rsp_data/o_rsp_err hold until the next response.
- Reset mid-read: abandons WAIT_RD with no response pulse; the pointer returns to its reset value.
- Requests whose i_req_valid drops before ready are simply not accepted.

Decomposition:
- Package reg_arb_pkg:
  - state enum (IDLE, WAIT_RD)
  - clog2-derived constants: index width, timeout counter width
  - function to slice a packed request field by index
- Sub-module rr_arbiter (parameter N): inputs i_req[N], i_last_idx; outputs o_grant one-hot and o_idx. Purely combinational, instantiated once.
- FSM, counter and output registers live in the top.

Test Plan:
- Single write: req0 we=1, addr=0x05, value=0xDEADBEEF -> ready0 at T, o_w_en=1 at T+1 with those values; no rsp pulse.
- Read, latency 3: req1 read addr=0x0A; register returns 0x12345678 three cycles after o_r_en -> o_rsp_valid=2'b10, err=0, data=0x12345678 on the next cycle; o_busy high throughout WAIT_RD.
- Fairness: both requesters issue writes continuously for 6 accepts -> grant order 0,1,0,1,0,1; o_w_en high 6 consecutive cycles.
- Timeout: TIMEOUT=8, read from req0 with i_r_valid never asserted -> rsp_valid[0] with err=1 and data=0 exactly 8 cycles after o_r_en; a subsequent late i_r_valid is ignored.
- Read blocking: req0 read pending, req1 write valid -> ready1 stays 0 until the response cycle; the write issues the cycle after.
- Reset during WAIT_RD -> all outputs 0 immediately, no rsp pulse; the next request from req1 is granted after req0 priority is checked.
